recip_arbiter: RTL and testbench

- Shares one fixed-point reciprocal unit (start_calc/done/x_in/x_inv/invalid interface) among N requesters.
- Round-robin grant. The granted operand is held stable on the unit's input for the whole calculation, and the single result is returned on a tagged response channel with valid/ready backpressure.
- A watchdog counter bounds the wait for done and raises a sticky fault if the unit hangs.
- Sits between the watchdog datapath clients and the reciprocal unit.

---
 rtl/watchdog_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/recip_arbiter.sv | 115 +++++++++++
 tb/tb_recip_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watchdog_pkg.sv
// Shared types for the reciprocal-unit arbiter: FSM state encoding and
// the default watchdog bound.
package watchdog_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } arb_st_t;

    localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping at N.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any_req
);

    logic [IDW-1:0] j;

    // Walk from the far end so the closest match to ptr is written last.
    always_comb begin
        idx = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IDW'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
    end

    assign any_req = |req;

    always_comb begin
        grant      = '0;
        grant[idx] = any_req;
    end

endmodule

// File: rtl/recip_arbiter.sv
// Shares one reciprocal unit among N requesters: round-robin grant, one
// operation in flight, tagged response with backpressure, hang watchdog.
module recip_arbiter
    import watchdog_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_invalid,
    output logic           rsp_timeout,
    output logic           recip_start,
    output logic [W-1:0]   recip_x,
    input  logic           recip_done,
    input  logic [W-1:0]   recip_x_inv,
    input  logic           recip_invalid,
    output logic           busy,
    output logic           fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_st_t        state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_reg;
    logic [W-1:0]   op_reg;
    logic [CW-1:0]  wd_cnt;
    logic [CW-1:0]  wd_nxt;
    logic [N-1:0]   g_vec;
    logic [IDW-1:0] g_idx;
    logic           any_req;
    logic [W-1:0]   g_data;

    rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (g_vec),
        .idx     (g_idx),
        .any_req (any_req)
    );

    assign g_data    = req_data[int'(g_idx)*W +: W];
    assign req_ready = (state == IDLE) ? g_vec : '0;
    assign busy      = (state != IDLE);
    assign rsp_id    = id_reg;
    assign recip_x   = (state == ISSUE || state == WAIT || state == DRAIN) ? op_reg : '0;
    assign wd_nxt    = wd_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            id_reg      <= '0;
            op_reg      <= '0;
            wd_cnt      <= '0;
            recip_start <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_invalid <= 1'b0;
            rsp_timeout <= 1'b0;
            fault       <= 1'b0;
        end else begin
            recip_start <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    op_reg      <= g_data;
                    id_reg      <= g_idx;
                    ptr         <= (g_idx == IDW'(N - 1)) ? '0 : g_idx + 1'b1;
                    recip_start <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_nxt;
                    // done takes priority over an abort landing in the same cycle
                    if (recip_done) begin
                        rsp_data    <= recip_x_inv;
                        rsp_invalid <= recip_invalid;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (wd_nxt == CW'(TIMEOUT - 1)) begin
                        rsp_data    <= '0;
                        rsp_invalid <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        fault       <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= rsp_timeout ? DRAIN : IDLE;
                end
                // a hung unit may still answer late; its result must not leak into the next op
                DRAIN: if (recip_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recip_arbiter.sv
// Randomised and directed bench for recip_arbiter with a transaction-level
// model and a behavioural reciprocal unit stand-in.
module tb_recip_arbiter;
    import watchdog_pkg::*;

    localparam int N = 4, W = 32, IDW = 2, TIMEOUT = 32, L = 10;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*W-1:0] req_data = '0;
    logic rsp_valid, rsp_ready = 1'b1, rsp_invalid, rsp_timeout;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0] rsp_data, recip_x, recip_x_inv;
    logic recip_start, recip_done, recip_invalid, busy, fault;

    recip_arbiter #(.N(N), .W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_invalid(rsp_invalid),
        .rsp_timeout(rsp_timeout), .recip_start(recip_start), .recip_x(recip_x),
        .recip_done(recip_done), .recip_x_inv(recip_x_inv),
        .recip_invalid(recip_invalid), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name, input int bound);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no event within %0d cycles (cycle %0d)", name, bound, cyc);
    endtask

    function automatic logic [W-1:0] recip_of(input logic [W-1:0] x);
        if ($signed(x) <= 0) return '0;
        return W'(64'h1_0000_0000 / {32'd0, x});
    endfunction

    function automatic logic [W-1:0] rand_x();
        int unsigned r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return 32'h8000_0000 | W'($urandom);
        if (r < 6) return W'($urandom_range(2, 32'h000F_FFFF));
        return W'($urandom_range(2, 32'h7FFF_FFFF));
    endfunction

    // ---------------- reciprocal unit stand-in ----------------
    logic hang = 1'b0, inject = 1'b0;
    int st_cyc = -100;
    logic [W-1:0] st_x = '0;
    initial begin
        recip_done = 1'b0; recip_x_inv = '0; recip_invalid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (inject || (!hang && cyc == st_cyc + L)) begin
                recip_done    = 1'b1;
                recip_x_inv   = recip_of(st_x);
                recip_invalid = ($signed(st_x) <= 0);
                inject        = 1'b0;
            end else begin
                recip_done    = 1'b0;
                recip_x_inv   = W'($urandom);
                recip_invalid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (!rst_n) st_cyc = -100;
            else if (recip_start) begin st_cyc = cyc; st_x = recip_x; end
        end
    end

    // ---------------- requester driver ----------------
    logic drop_acc = 1'b1, rnd = 1'b0;
    logic [N-1:0] acc;
    initial forever begin
        @(negedge clk); acc = req_ready & req_valid;
        @(posedge clk); #1;
        if (drop_acc) req_valid = req_valid & ~acc;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*W +: W] = rand_x();
                    end
                end else if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- model + per-cycle compare ----------------
    logic m_free = 1'b1, m_act = 1'b0, m_drain = 1'b0, m_fault = 1'b0, m_to = 1'b0;
    int m_ptr = 0, m_due = 0, m_gcyc = 0, m_id = 0;
    logic [W-1:0] m_x = '0;
    int n_grants = 0, n_starts = 0, d_gidx = 0, d_gcyc = 0, d_scyc = 0, d_rcyc = 0, hs_cyc = 0;
    int glog[$];
    logic prev_rv = 1'b0;
    int g;
    logic [N-1:0] exp_rr;
    logic exp_rv;
    logic [W-1:0] exp_x;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_free = 1'b1; m_act = 1'b0; m_drain = 1'b0; m_fault = 1'b0; m_ptr = 0; prev_rv = 1'b0;
        end else begin
            if (req_ready != '0) begin
                n_grants++; d_gcyc = cyc;
                for (int i = 0; i < N; i++) if (req_ready[i]) d_gidx = i;
                glog.push_back(d_gidx);
            end
            if (recip_start) begin n_starts++; d_scyc = cyc; end
            if (rsp_valid && !prev_rv) d_rcyc = cyc;
            prev_rv = rsp_valid;
            if (rsp_valid && rsp_ready) hs_cyc = cyc;

            g = -1; exp_rr = '0;
            if (m_free && (|req_valid)) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                exp_rr[g] = 1'b1;
            end
            exp_rv = m_act && (cyc >= m_due);
            if (exp_rv && m_to) m_fault = 1'b1;
            exp_x = ((m_act && !exp_rv && cyc > m_gcyc) || m_drain) ? m_x : '0;

            check("req_ready", req_ready, exp_rr);
            check("recip_start", recip_start, m_act && cyc == m_gcyc + 1);
            check("recip_x", recip_x, exp_x);
            check("rsp_valid", rsp_valid, exp_rv);
            check("busy", busy, !m_free);
            check("fault", fault, m_fault);
            if (exp_rv) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_data", rsp_data, m_to ? '0 : recip_of(m_x));
                check("rsp_invalid", rsp_invalid, m_to || ($signed(m_x) <= 0));
                check("rsp_timeout", rsp_timeout, m_to);
            end

            if (m_drain && recip_done) begin m_drain = 1'b0; m_free = 1'b1; end
            if (exp_rv && rsp_ready) begin
                m_act = 1'b0;
                if (m_to) m_drain = 1'b1; else m_free = 1'b1;
            end
            if (g >= 0) begin
                m_free = 1'b0; m_act = 1'b1; m_id = g; m_x = req_data[g*W +: W];
                m_gcyc = cyc; m_to = hang;
                m_due = cyc + 1 + (hang ? TIMEOUT : L + 1);
                m_ptr = (g + 1) % N;
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick(); @(posedge clk); #2; endtask

    task automatic wait_grant(input int bound, input string nm);
        int n0 = n_grants; int k = 0;
        while (n_grants == n0 && k < bound) begin tick(); k++; end
        if (n_grants == n0) expire(nm, bound);
    endtask

    task automatic wait_start(input int bound, input string nm);
        int n0 = n_starts; int k = 0;
        while (n_starts == n0 && k < bound) begin tick(); k++; end
        if (n_starts == n0) expire(nm, bound);
    endtask

    task automatic wait_rsp(input int bound, input string nm);
        int k = 0;
        while (!rsp_valid && k < bound) begin tick(); k++; end
        if (!rsp_valid) expire(nm, bound);
        @(negedge clk); #1;
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int k = 0;
        while ((busy || rsp_valid || (|req_valid)) && k < bound) begin tick(); k++; end
        if (busy || rsp_valid || (|req_valid)) expire(nm, bound);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".req_ready"}, req_ready, 0);
        check({tag, ".rsp_valid"}, rsp_valid, 0);
        check({tag, ".rsp_id"}, rsp_id, 0);
        check({tag, ".rsp_data"}, rsp_data, 0);
        check({tag, ".rsp_invalid"}, rsp_invalid, 0);
        check({tag, ".rsp_timeout"}, rsp_timeout, 0);
        check({tag, ".recip_start"}, recip_start, 0);
        check({tag, ".recip_x"}, recip_x, 0);
        check({tag, ".fault"}, fault, 0);
        check({tag, ".busy"}, busy, 0);
    endtask

    int rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n0, s0, k;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // round robin: all four held high
        drop_acc = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(32'h0001_0000 * (i + 2));
        glog.delete();
        req_valid = '1;
        k = 0;
        while (glog.size() < 5 && k < 200) begin tick(); k++; end
        req_valid = '0;
        if (glog.size() < 5) expire("rr_grants", 200);
        else for (int i = 0; i < 5; i++) check("rr_order", glog[i], rr_exp[i]);
        drop_acc = 1'b1;
        wait_idle(100, "rr_idle");

        // single request, 2.0 in Q16
        req_data[1*W +: W] = 32'h0002_0000;
        req_valid[1] = 1'b1;
        wait_rsp(50, "single_rsp");
        check("single.rsp_id", rsp_id, 1);
        check("single.rsp_data", rsp_data, 32'h0000_8000);
        check("single.rsp_invalid", rsp_invalid, 0);
        check("single.start_lat", d_scyc - d_gcyc, 1);
        wait_idle(50, "single_idle");

        // invalid operand -1.0
        req_data[2*W +: W] = 32'hFFFF_0000;
        req_valid[2] = 1'b1;
        wait_rsp(50, "inv_rsp");
        check("inv.rsp_id", rsp_id, 2);
        check("inv.rsp_data", rsp_data, 0);
        check("inv.rsp_invalid", rsp_invalid, 1);
        check("inv.fault", fault, 0);
        wait_idle(50, "inv_idle");

        // backpressure
        rsp_ready = 1'b0;
        req_data[0*W +: W] = 32'h0004_0000;
        req_valid[0] = 1'b1;
        wait_rsp(50, "bp_rsp");
        req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        n0 = n_grants; s0 = n_starts;
        repeat (20) tick();
        check("bp.grants", n_grants, n0);
        check("bp.starts", n_starts, s0);
        check("bp.rsp_valid", rsp_valid, 1);
        check("bp.rsp_id", rsp_id, 0);
        check("bp.rsp_data", rsp_data, 32'h0000_4000);
        rsp_ready = 1'b1;
        wait_grant(10, "bp_next_grant");
        check("bp.grant_gap", d_gcyc - hs_cyc, 1);
        check("bp.grant_idx", d_gidx, 1);
        wait_idle(100, "bp_idle");

        // timeout: unit never answers
        hang = 1'b1;
        req_data[3*W +: W] = 32'h0003_0000;
        req_valid[3] = 1'b1;
        wait_start(10, "to_start");
        wait_rsp(60, "to_rsp");
        check("to.latency", d_rcyc - d_scyc, TIMEOUT);
        check("to.rsp_timeout", rsp_timeout, 1);
        check("to.rsp_invalid", rsp_invalid, 1);
        check("to.rsp_data", rsp_data, 0);
        check("to.fault", fault, 1);
        tick();
        req_valid[0] = 1'b1; req_valid[2] = 1'b1;
        n0 = n_grants;
        repeat (15) tick();
        check("to.drain_busy", busy, 1);
        check("to.drain_grants", n_grants, n0);
        hang = 1'b0;
        inject = 1'b1;
        wait_grant(10, "to_resume");
        check("to.resume_idx", d_gidx, 0);
        wait_idle(100, "to_idle");

        // reset mid-WAIT
        req_data[1*W +: W] = 32'h0003_0000;
        req_valid[1] = 1'b1;
        wait_start(10, "rst_start");
        repeat (5) tick();
        rst_n = 1'b0; req_valid = '0;
        #1;
        check_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(32'h0000_1000 << i);
        req_valid = '1;
        wait_grant(10, "rst_regrant");
        check("midrst.ptr_idx", d_gidx, 0);
        wait_idle(200, "rst_idle");

        // randomised traffic
        rnd = 1'b1;
        repeat (4000) tick();
        rnd = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(200, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
